// File: rtl/serial_subtractor.sv
// serial_subtractor: debounced-button-started bit-serial A-B, one full-subtractor cell, LSB first
module serial_subtractor #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic [2*WIDTH-1:0] SW,
  input  logic               BTNC,
  output logic [WIDTH+1:0]   led
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state;
  logic [1:0]       sync;
  logic             level, level_q, start;
  logic [DW-1:0]    db_cnt;
  logic             db_done;
  logic [WIDTH-1:0] a, b, r, r_next;
  logic [CW-1:0]    cnt;
  logic             bin, d, bout;
  assign start   = level & ~level_q;
  assign db_done = db_cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign d       = a[0] ^ b[0] ^ bin;
  assign bout    = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & bin);
  // Difference bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts
  assign r_next  = WIDTH'({d, r} >> 1);
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync    <= {sync[0], BTNC};
      level_q <= level;
      db_cnt  <= (sync[1] == level || db_done) ? '0 : db_cnt + DW'(1);
      if (sync[1] != level && db_done) level <= ~level;
    end
  end
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state <= IDLE;
      led   <= '0;
      a     <= '0;
      b     <= '0;
      r     <= '0;
      cnt   <= '0;
      bin   <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a            <= SW[WIDTH-1:0];
        b            <= SW[2*WIDTH-1:WIDTH];
        bin          <= 1'b0;
        cnt          <= '0;
        led[WIDTH+1] <= 1'b1;
        state        <= RUN;
      end
    end else begin
      a   <= a >> 1;
      b   <= b >> 1;
      bin <= bout;
      cnt <= cnt + CW'(1);
      r   <= r_next;
      if (cnt == CW'(WIDTH - 1)) begin
        led   <= {1'b0, bout, r_next};
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vector table plus multi-cycle corner sequences and an exhaustive sweep
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       CPU_RESETN = 1'b0;
  logic [7:0] SW = '0;
  logic       BTNC = 1'b0;
  logic [5:0] led;
  int         cmp = 0;
  int         fails = 0;
  int         ops = 0;
  logic       busy_q = 1'b0;

  serial_subtractor #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(CPU_RESETN), .SW(SW), .BTNC(BTNC), .led(led)
  );

  always #5 clk = ~clk;

  // Count busy windows independently of the checking code
  always @(posedge clk) begin
    busy_q <= led[5];
    if (led[5] && !busy_q) ops <= ops + 1;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic       borrow;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input string nm);
    int t = 0;
    while (!led[5] && t < 60) begin
      tick(1);
      t++;
    end
    chk({nm, " start timeout"}, 32'(t < 60), 1);
  endtask

  // Count the busy window while checking that led[4:0] holds its old value
  task automatic run_window(input string nm, input logic [4:0] prev, output int n);
    n = 0;
    while (led[5] && n < 20) begin
      chk({nm, " hold"}, {27'd0, led[4:0]}, {27'd0, prev});
      n++;
      tick(1);
    end
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ed, input logic eb, input string nm);
    logic [4:0] prev;
    int n;
    prev = led[4:0];
    SW = {b, a};
    BTNC = 1'b1;
    wait_busy(nm);
    run_window(nm, prev, n);
    chk({nm, " busy len"}, n, 4);
    chk({nm, " result"}, {26'd0, led}, {26'd0, 1'b0, eb, ed});
    BTNC = 1'b0;
    tick(12);
  endtask

  initial begin
    vec_t vecs[$];
    logic [4:0] prev;
    int n, o0, busy_cycles;
    vecs = '{
      '{4'h9, 4'h3, 4'h6, 1'b0},
      '{4'h3, 4'h9, 4'hA, 1'b1},
      '{4'h0, 4'hF, 4'h1, 1'b1},
      '{4'hF, 4'hF, 4'h0, 1'b0},
      '{4'h0, 4'h1, 4'hF, 1'b1},
      '{4'hF, 4'h0, 4'hF, 1'b0},
      '{4'h5, 4'hA, 4'hB, 1'b1},
      '{4'h8, 4'h7, 4'h1, 1'b0}
    };
    tick(3);
    chk("reset led", {26'd0, led}, 0);
    CPU_RESETN = 1'b1;
    tick(2);
    chk("idle led", {26'd0, led}, 0);

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, $sformatf("vec%0d", i));

    // Short glitches must never start an operation
    o0 = ops;
    prev = led[4:0];
    for (int g = 1; g <= 3; g++) begin
      BTNC = 1'b1;
      tick(g);
      BTNC = 1'b0;
      tick(10);
    end
    chk("glitch ops", ops - o0, 0);
    chk("glitch led", {26'd0, led}, {27'd0, prev});

    // Long hold gives exactly one 4-cycle busy window
    o0 = ops;
    busy_cycles = 0;
    SW = 8'h39;
    BTNC = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      tick(1);
      busy_cycles += int'(led[5]);
    end
    BTNC = 1'b0;
    tick(12);
    chk("hold ops", ops - o0, 1);
    chk("hold busy cycles", busy_cycles, 4);
    chk("hold result", {26'd0, led}, 32'h06);

    // Mid-run SW change and button bounce do not disturb the captured operands
    o0 = ops;
    prev = led[4:0];
    SW = 8'h57;
    BTNC = 1'b1;
    wait_busy("midrun");
    tick(1);
    SW = 8'h00;
    BTNC = 1'b0;
    tick(1);
    BTNC = 1'b1;
    chk("midrun hold", {27'd0, led[4:0]}, {27'd0, prev});
    run_window("midrun", prev, n);
    chk("midrun result", {26'd0, led}, 32'h02);
    BTNC = 1'b0;
    tick(30);
    chk("midrun ops", ops - o0, 1);

    // Reset during RUN cycle 2 abandons the operation
    SW = 8'h93;
    BTNC = 1'b1;
    wait_busy("reset");
    tick(1);
    BTNC = 1'b0;
    CPU_RESETN = 1'b0;
    tick(1);
    CPU_RESETN = 1'b1;
    chk("reset midrun led", {26'd0, led}, 0);
    o0 = ops;
    tick(20);
    chk("reset no op", ops - o0, 0);
    chk("reset still clear", {26'd0, led}, 0);
    do_op(4'h3, 4'h9, 4'hA, 1'b1, "after reset");

    // Exhaustive sweep against (A-B) mod 16 and A<B
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        do_op(4'(x), 4'(y), 4'((x - y) & 15), x < y, $sformatf("sweep a=%0d b=%0d", x, y));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
